// File: rtl/observe_trigger_pkg.sv
// Shared types and config-field layout helpers for the observe-point sequence trigger.
// The config word is packed from the LSB: sticky, last_stage, then one record per stage.
package observe_trigger_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_e;

    localparam int STICKY_OFS = 0;
    localparam int LAST_OFS   = 1;
    // Offsets inside one stage record {hold, value, mask}, mask lowest.
    localparam int MASK_REL   = 0;

    function automatic int cfg_len(input int obs_w, input int n_stages, input int cnt_w);
        return n_stages * (2 * obs_w + cnt_w) + $clog2(n_stages) + 1;
    endfunction

    function automatic int stage_base(input int k, input int obs_w, input int n_stages,
                                      input int cnt_w);
        return LAST_OFS + $clog2(n_stages) + k * (2 * obs_w + cnt_w);
    endfunction

endpackage

// File: rtl/observe_trigger_cfg_chain.sv
// Serial config shift register; shifts left while cfg_en is high, MSB exits on cfg_out
// so several trigger blocks can be daisy-chained on one config line.
module trigger_cfg_chain
    import observe_trigger_pkg::*;
#(
    parameter int CFG_LEN = 99
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_en,
    input  logic               cfg_bit,
    output logic               cfg_out,
    output logic [CFG_LEN-1:0] cfg_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
        end else if (cfg_en) begin
            cfg_q <= {cfg_q[CFG_LEN-2:0], cfg_bit};
        end
    end

    assign cfg_out = cfg_q[CFG_LEN-1];

endmodule

// File: rtl/observe_trigger.sv
// Programmable sequence trigger: walks a chain of mask/value stages over the observe bus,
// each stage needing hold+1 consecutive matches, and raises a registered trigger at the end.
module observe_trigger
    import observe_trigger_pkg::*;
#(
    parameter int OBS_W    = 8,
    parameter int N_STAGES = 4,
    parameter int CNT_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [OBS_W-1:0]            obs,
    input  logic                        cfg_en,
    input  logic                        cfg_bit,
    output logic                        cfg_out,
    input  logic                        arm,
    output logic                        trigger,
    output logic [$clog2(N_STAGES)-1:0] stage,
    output logic                        busy
);

    localparam int SEL_W   = $clog2(N_STAGES);
    localparam int CFG_LEN = cfg_len(OBS_W, N_STAGES, CNT_W);

    logic [CFG_LEN-1:0] cfg_q;
    logic               sticky;
    logic [SEL_W-1:0]   last_stage;
    logic [N_STAGES-1:0] match_k;
    logic [CNT_W-1:0]   hold_k [N_STAGES];
    logic               match_sel;
    logic [CNT_W-1:0]   hold_sel;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   stage_q, stage_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    trigger_cfg_chain #(
        .CFG_LEN(CFG_LEN)
    ) u_cfg_chain (
        .clk    (clk),
        .rst_n  (rst_n),
        .cfg_en (cfg_en),
        .cfg_bit(cfg_bit),
        .cfg_out(cfg_out),
        .cfg_q  (cfg_q)
    );

    assign sticky     = cfg_q[STICKY_OFS];
    assign last_stage = cfg_q[LAST_OFS +: SEL_W];

    // Config is read live, so a freshly shifted word applies on the next ARMED cycle.
    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        localparam int BASE = stage_base(k, OBS_W, N_STAGES, CNT_W);
        logic [OBS_W-1:0] mask;
        logic [OBS_W-1:0] value;
        assign mask       = cfg_q[BASE + MASK_REL +: OBS_W];
        assign value      = cfg_q[BASE + OBS_W +: OBS_W];
        assign hold_k[k]  = cfg_q[BASE + 2 * OBS_W +: CNT_W];
        assign match_k[k] = ((obs ^ value) & mask) == '0;
    end

    assign match_sel = match_k[stage_q];
    assign hold_sel  = hold_k[stage_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (cfg_en || !arm) begin
            state_d = IDLE;
            stage_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARMED;
                    stage_d = '0;
                    cnt_d   = '0;
                end
                ARMED: begin
                    // cnt_q counts earlier matches, so this match is number cnt_q+1.
                    if (!match_sel) begin
                        cnt_d = '0;
                    end else if (cnt_q >= hold_sel) begin
                        cnt_d = '0;
                        if (stage_q == last_stage) begin
                            state_d = FIRED;
                        end else begin
                            stage_d = stage_q + 1'b1;
                        end
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                FIRED: begin
                    if (!sticky) begin
                        state_d = ARMED;
                        stage_d = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    stage_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign trigger = (state_q == FIRED);
    assign busy    = (state_q == ARMED);
    assign stage   = stage_q;

endmodule
